// File: rtl/mode2_pkg.sv
// Shared state encoding, constants and helpers for the Mode 2 round controller.
package mode2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        SHOW,
        WAIT,
        SCORE,
        FAIL
    } state_t;

    localparam logic [23:0] BCD_NONE  = 24'h999999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [23:0] to_bcd6(input int unsigned value);
        logic [23:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter6.sv
// Six-digit BCD counter: clear, +1, +STEP, saturating at LIMIT (BCD) with a limit flag.
module bcd_counter6 #(
    parameter logic [23:0] LIMIT = 24'h009999,
    parameter logic [23:0] STEP  = 24'h000100
) (
    input  logic        cin,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    input  logic        add,
    output logic [23:0] count,
    output logic        at_limit
);

    function automatic logic [24:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
        logic [24:0] r;
        logic [4:0]  d;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = d[3:0];
        end
        r[24] = c;
        return r;
    endfunction

    logic [24:0] sum;
    logic [23:0] next_val;

    // BCD digits compare in the same order as their binary magnitude.
    always_comb begin
        sum      = bcd_add(count, add ? STEP : 24'h000001);
        next_val = (sum[24] || (sum[23:0] >= LIMIT)) ? LIMIT : sum[23:0];
    end

    assign at_limit = (count >= LIMIT);

    always_ff @(posedge cin) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (add || inc) begin
            count <= next_val;
        end
    end

endmodule

// File: rtl/mode2_round_ctrl.sv
// Mode 2 pattern-match reaction round: random delay, show target, time the match in BCD ms.
// Define MODE2_PENALTY_EN to add PENALTY_MS for each new wrong non-zero pattern during WAIT.
module mode2_round_ctrl
    import mode2_pkg::*;
#(
    parameter int CLK_PER_MS   = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_MASK   = 2047,
    parameter int TIMEOUT_MS   = 9999,
    parameter int PENALTY_MS   = 100
) (
    input  logic        cin,
    input  logic        reset,
    input  logic        selection,
    input  logic        key,
    input  logic [7:0]  sw,
    output logic [9:0]  light2,
    output logic        signal2,
    output logic [23:0] reaction_time,
    output logic [23:0] highscore_mode2,
    output logic        busy
);

    localparam int             PW          = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]  PRESC_LAST  = PW'(CLK_PER_MS - 1);
    localparam logic [10:0]    DMASK       = 11'(DELAY_MASK);
    localparam logic [15:0]    DMIN        = 16'(MIN_DELAY_MS);
    localparam logic [23:0]    TIMEOUT_BCD = to_bcd6(TIMEOUT_MS);
    localparam logic [23:0]    PENALTY_BCD = to_bcd6(PENALTY_MS);

    state_t        state, state_nx;
    logic [15:0]   lfsr;
    logic [PW-1:0] presc;
    logic          key_q;
    logic [15:0]   delay_cnt;
    logic [7:0]    target;
    logic [23:0]   count;
    logic          key_rise, tick, match, penalty, at_limit;
    logic          cnt_clr, cnt_inc, cnt_add;

    assign key_rise = key & ~key_q;
    assign tick     = (presc == PRESC_LAST);
    assign match    = (sw == target);

`ifdef MODE2_PENALTY_EN
    logic [7:0] sw_q;
    always_ff @(posedge cin) begin
        if (reset) sw_q <= '0;
        else       sw_q <= sw;
    end
    assign penalty = (sw != sw_q) && (sw != 8'h00) && !match;
`else
    assign penalty = 1'b0;
`endif

    bcd_counter6 #(
        .LIMIT(TIMEOUT_BCD),
        .STEP (PENALTY_BCD)
    ) u_react (
        .cin     (cin),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .add     (cnt_add),
        .count   (count),
        .at_limit(at_limit)
    );

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_add  = 1'b0;
        light2   = '0;
        signal2  = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (key_rise && (sw == 8'h00)) state_nx = DELAY;
            end
            DELAY: begin
                light2[9] = 1'b1;
                busy      = 1'b1;
                if (sw != 8'h00)            state_nx = FAIL;
                else if (delay_cnt == 16'd0) state_nx = SHOW;
            end
            SHOW: begin
                light2   = {2'b10, target};
                busy     = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                light2 = {2'b10, target};
                busy   = 1'b1;
                // A match outranks both timeout and a coincident tick.
                if (match)         state_nx = SCORE;
                else if (at_limit) state_nx = FAIL;
                else if (penalty)  cnt_add  = 1'b1;
                else if (tick)     cnt_inc  = 1'b1;
            end
            SCORE: begin
                signal2  = 1'b1;
                state_nx = IDLE;
            end
            FAIL: begin
                light2[8] = 1'b1;
                if (key_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!selection) state_nx = IDLE;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cin) begin
        if (reset) begin
            state           <= IDLE;
            lfsr            <= LFSR_SEED;
            presc           <= '0;
            key_q           <= 1'b0;
            delay_cnt       <= '0;
            target          <= 8'h01;
            reaction_time   <= '0;
            highscore_mode2 <= BCD_NONE;
        end else begin
            state <= state_nx;
            lfsr  <= lfsr_next(lfsr);
            key_q <= key;

            if (state_nx != state || tick) presc <= '0;
            else                           presc <= presc + 1'b1;

            if (state == IDLE && state_nx == DELAY) begin
                delay_cnt <= DMIN + {5'd0, lfsr[10:0] & DMASK};
                target    <= (lfsr[7:0] == 8'h00) ? 8'h01 : lfsr[7:0];
            end else if (state == DELAY && tick && delay_cnt != 16'd0) begin
                delay_cnt <= delay_cnt - 16'd1;
            end

            if (state == SCORE) begin
                reaction_time <= count;
                if (count < highscore_mode2) highscore_mode2 <= count;
            end else if (state == FAIL) begin
                reaction_time <= BCD_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mode2_round_ctrl.sv
// Self-checking bench for mode2_round_ctrl: integer-millisecond round model plus directed rounds.
module tb_mode2_round_ctrl;

    localparam int CPM    = 4;
    localparam int MIN_MS = 3;
    localparam int MASK   = 7;
    localparam int PEN_MS = 100;
    localparam int TO_A   = 9999;
    localparam int TO_B   = 12;

    localparam int M_IDLE = 0, M_DELAY = 1, M_SHOW = 2, M_WAIT = 3, M_SCORE = 4, M_FAIL = 5;

    logic       cin = 1'b0;
    logic       reset = 1'b1;
    logic       key = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       sel_a = 1'b0;
    logic       sel_b = 1'b0;

    logic [9:0]  light2_a, light2_b;
    logic        signal2_a, signal2_b, busy_a, busy_b;
    logic [23:0] rt_a, rt_b, hs_a, hs_b;

    int total = 0;
    int bad   = 0;

    always #5 cin = ~cin;

    mode2_round_ctrl #(
        .CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN_MS), .DELAY_MASK(MASK),
        .TIMEOUT_MS(TO_A), .PENALTY_MS(PEN_MS)
    ) dut_a (
        .cin(cin), .reset(reset), .selection(sel_a), .key(key), .sw(sw),
        .light2(light2_a), .signal2(signal2_a), .reaction_time(rt_a),
        .highscore_mode2(hs_a), .busy(busy_a)
    );

    mode2_round_ctrl #(
        .CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN_MS), .DELAY_MASK(MASK),
        .TIMEOUT_MS(TO_B), .PENALTY_MS(PEN_MS)
    ) dut_b (
        .cin(cin), .reset(reset), .selection(sel_b), .key(key), .sw(sw),
        .light2(light2_b), .signal2(signal2_b), .reaction_time(rt_b),
        .highscore_mode2(hs_b), .busy(busy_b)
    );

    function automatic logic [23:0] bcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round model: times and scores kept as plain integers in ms, 999999 meaning "none".
    logic [15:0] m_lfsr;
    logic        m_key_q;
    logic [7:0]  m_sw_q;
    bit          m_valid = 1'b0;
    bit          m_rise;
    int          m_st[2], m_pre[2], m_dly[2], m_ms[2], m_rt[2], m_hs[2];
    logic [7:0]  m_tgt[2];
    int          sig_cnt[2];

    task automatic model_step(input int k, input bit sel, input int tmo);
        int ns;
        bit tick, pen;
        tick = (m_pre[k] == CPM - 1);
        ns   = m_st[k];
        if (m_st[k] == M_SCORE) begin
            m_rt[k] = m_ms[k];
            if (m_ms[k] < m_hs[k]) m_hs[k] = m_ms[k];
        end
        if (m_st[k] == M_FAIL) m_rt[k] = 999999;
        if (!sel) begin
            ns = M_IDLE;
        end else begin
            case (m_st[k])
                M_IDLE: if (m_rise && sw == 8'h00) begin
                    ns       = M_DELAY;
                    m_dly[k] = MIN_MS + (int'(m_lfsr[10:0]) & MASK);
                    m_tgt[k] = (m_lfsr[7:0] == 8'h00) ? 8'h01 : m_lfsr[7:0];
                end
                M_DELAY: begin
                    if (sw != 8'h00)      ns = M_FAIL;
                    else if (m_dly[k] == 0) ns = M_SHOW;
                    else if (tick)        m_dly[k]--;
                end
                M_SHOW: begin
                    m_ms[k] = 0;
                    ns      = M_WAIT;
                end
                M_WAIT: begin
                    pen = 1'b0;
`ifdef MODE2_PENALTY_EN
                    pen = (sw != m_sw_q) && (sw != 8'h00);
`endif
                    if (sw == m_tgt[k])   ns = M_SCORE;
                    else if (m_ms[k] >= tmo) ns = M_FAIL;
                    else if (pen)         m_ms[k] = (m_ms[k] + PEN_MS > tmo) ? tmo : m_ms[k] + PEN_MS;
                    else if (tick)        m_ms[k]++;
                end
                M_SCORE: ns = M_IDLE;
                M_FAIL:  if (m_rise) ns = M_IDLE;
                default: ns = M_IDLE;
            endcase
        end
        if (ns != m_st[k] || tick) m_pre[k] = 0;
        else                       m_pre[k]++;
        m_st[k] = ns;
    endtask

    always @(posedge cin) begin
        if (reset) begin
            m_valid = 1'b1;
            m_lfsr  = 16'hACE1;
            m_key_q = 1'b0;
            m_sw_q  = 8'h00;
            for (int k = 0; k < 2; k++) begin
                m_st[k] = M_IDLE; m_pre[k] = 0; m_dly[k] = 0; m_ms[k] = 0;
                m_rt[k] = 0; m_hs[k] = 999999; m_tgt[k] = 8'h01;
            end
        end else if (m_valid) begin
            m_rise = key && !m_key_q;
            model_step(0, sel_a, TO_A);
            model_step(1, sel_b, TO_B);
            m_lfsr  = lfsr_step(m_lfsr);
            m_key_q = key;
            m_sw_q  = sw;
        end
    end

    task automatic cmp_inst(input int k, input logic [9:0] l2, input logic s2,
                            input logic [23:0] rt, input logic [23:0] hs, input logic bsy);
        logic [9:0] e_l2;
        case (m_st[k])
            M_DELAY:        e_l2 = 10'h200;
            M_SHOW, M_WAIT: e_l2 = {2'b10, m_tgt[k]};
            M_FAIL:         e_l2 = 10'h100;
            default:        e_l2 = 10'h000;
        endcase
        check((k == 0) ? "cycle_a" : "cycle_b",
              {l2, s2, rt, hs, bsy},
              {e_l2, m_st[k] == M_SCORE, bcd(m_rt[k]), bcd(m_hs[k]),
               m_st[k] == M_DELAY || m_st[k] == M_SHOW || m_st[k] == M_WAIT});
        if (s2 === 1'b1) sig_cnt[k]++;
    endtask

    always @(negedge cin) begin
        if (m_valid) begin
            cmp_inst(0, light2_a, signal2_a, rt_a, hs_a, busy_a);
            cmp_inst(1, light2_b, signal2_b, rt_b, hs_b, busy_b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge cin);
        #1;
    endtask

    task automatic press_key();
        key = 1'b1;
        step(1);
        key = 1'b0;
        step(1);
    endtask

    task automatic wait_state(input int k, input int s, input int budget, input string name);
        int n;
        n = 0;
        while (m_st[k] != s && n < budget) begin
            step(1);
            n++;
        end
        if (m_st[k] != s) begin
            total++;
            bad++;
            $display("FAIL %s: gave up after %0d cycles in state %0d, wanted %0d", name, n, m_st[k], s);
        end
    endtask

    task automatic wait_ms(input int k, input int v, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_st[k] == M_WAIT && m_ms[k] == v) && n < budget) begin
            step(1);
            n++;
        end
        if (!(m_st[k] == M_WAIT && m_ms[k] == v)) begin
            total++;
            bad++;
            $display("FAIL %s: gave up after %0d cycles waiting for %0d ms", name, n, v);
        end
    endtask

    int          s0, n;
    logic [7:0]  wrong;
    logic [23:0] hs_after_pen;

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        check("reset_light2", light2_a, 10'h000);
        check("reset_hs", hs_a, 24'h999999);
        check("reset_rt", rt_a, 24'h000000);
        check("reset_busy", busy_a, 1'b0);

        // Round 1: match at 25 ms sets the first best time.
        sel_a = 1'b1;
        step(1);
        s0 = sig_cnt[0];
        press_key();
        check("start_busy", busy_a, 1'b1);
        wait_state(0, M_WAIT, 200, "show_r1");
        wait_ms(0, 25, 400, "ms_r1");
        check("wait_lamps", light2_a, {2'b10, m_tgt[0]});
        sw = m_tgt[0];
        wait_state(0, M_IDLE, 10, "score_r1");
        check("r1_rt", rt_a, 24'h000025);
        check("r1_hs", hs_a, 24'h000025);
        check("r1_pulses", sig_cnt[0] - s0, 1);
        sw = 8'h00;
        step(2);

        // Round 2: slower match leaves the best time alone.
        press_key();
        wait_state(0, M_WAIT, 200, "show_r2");
        wait_ms(0, 40, 400, "ms_r2");
        sw = m_tgt[0];
        wait_state(0, M_IDLE, 10, "score_r2");
        check("r2_rt", rt_a, 24'h000040);
        check("r2_hs", hs_a, 24'h000025);
        sw = 8'h00;
        step(2);

        // False start during the delay.
        s0 = sig_cnt[0];
        press_key();
        check("fs_busy", busy_a, 1'b1);
        sw = 8'h10;
        step(2);
        check("fs_lamp", light2_a, 10'h100);
        check("fs_rt", rt_a, 24'h999999);
        check("fs_hs", hs_a, 24'h000025);
        check("fs_pulses", sig_cnt[0] - s0, 0);
        sw = 8'h00;
        press_key();
        check("fs_exit", light2_a, 10'h000);

        // Count crossing 99 -> 100.
        press_key();
        wait_state(0, M_WAIT, 200, "show_carry");
        wait_ms(0, 103, 600, "ms_carry");
        sw = m_tgt[0];
        wait_state(0, M_IDLE, 10, "score_carry");
        check("carry_rt", rt_a, 24'h000103);
        sw = 8'h00;
        step(2);

        // One wrong non-zero pattern at 7 ms, then the match.
        press_key();
        wait_state(0, M_WAIT, 200, "show_pen");
        wait_ms(0, 7, 100, "ms_pen");
        wrong = (m_tgt[0] == 8'h01) ? 8'h02 : 8'h01;
        sw = wrong;
        step(1);
        sw = m_tgt[0];
        wait_state(0, M_IDLE, 10, "score_pen");
`ifdef MODE2_PENALTY_EN
        check("pen_rt", rt_a, 24'h000107);
        hs_after_pen = 24'h000025;
`else
        check("pen_rt", rt_a, 24'h000007);
        hs_after_pen = 24'h000007;
`endif
        check("pen_hs", hs_a, hs_after_pen);
        sw = 8'h00;
        step(2);

        // Selection dropped mid-wait.
        press_key();
        wait_state(0, M_WAIT, 200, "show_sel");
        wait_ms(0, 5, 100, "ms_sel");
        sel_a = 1'b0;
        step(1);
        check("sel_lamp", light2_a, 10'h000);
        check("sel_busy", busy_a, 1'b0);
        check("sel_hs", hs_a, hs_after_pen);

        // Timeout at 12 ms on the short-timeout instance: SHOW plus 49 WAIT cycles.
        sel_b = 1'b1;
        step(1);
        press_key();
        wait_state(1, M_SHOW, 200, "show_to");
        n = 0;
        while (light2_b[9] && light2_b[7:0] != 8'h00 && n < 200) begin
            n++;
            step(1);
        end
        check("to_cycles", n, 50);
        check("to_lamp", light2_b, 10'h100);
        step(1);
        check("to_rt", rt_b, 24'h999999);
        press_key();

        // Match on the same cycle the count reaches the timeout.
        press_key();
        wait_state(1, M_WAIT, 200, "show_tie");
        wait_ms(1, 12, 100, "ms_tie");
        sw = m_tgt[1];
        wait_state(1, M_IDLE, 10, "score_tie");
        check("tie_rt", rt_b, 24'h000012);
        check("tie_hs", hs_b, 24'h000012);
        sw = 8'h00;
        step(2);

        // Reset clears the best times.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("rst_hs_a", hs_a, 24'h999999);
        check("rst_hs_b", hs_b, 24'h999999);
        check("rst_rt_a", rt_a, 24'h000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
